// File: rtl/quad_pkg.sv
// quad_pkg: shared phase/direction types and Gray-state constants for the quadrature decoder.
package quad_pkg;
  typedef logic [1:0] phase_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_REV, DIR_ILLEGAL} dir_t;
  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;
  // Position of a Gray state along the forward cycle 00,01,11,10.
  function automatic logic [1:0] gray_pos(input phase_t p);
    return {p[1], p[1] ^ p[0]};
  endfunction
endpackage

// File: rtl/quad_encoder_if.sv
// quad_encoder_if: phase inputs, preset load and channel/strobe outputs of the decoder.
interface quad_encoder_if #(parameter int WIDTH = 8);
  logic a;
  logic b;
  logic load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] value;
  logic inc;
  logic dec;
  logic error;
  modport master(output a, b, load, load_value, input value, inc, dec, error);
  modport slave(input a, b, load, load_value, output value, inc, dec, error);
endinterface

// File: rtl/quad_dir_decode.sv
// quad_dir_decode: classifies one phase transition as none, forward, reverse or illegal.
module quad_dir_decode
  import quad_pkg::*;
(
  input  phase_t prev_ab,
  input  phase_t cur_ab,
  output dir_t   dir
);
  logic [1:0] d;
  always_comb begin
    d = gray_pos(cur_ab) - gray_pos(prev_ab);
    dir = d == 2'd0 ? DIR_NONE : d == 2'd1 ? DIR_FWD : d == 2'd3 ? DIR_REV : DIR_ILLEGAL;
  end
endmodule

// File: rtl/quad_encoder.sv
// quad_encoder: accumulates quadrature edges into detents and steps a wrapping or clamping value.
module quad_encoder
  import quad_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter int STEP             = 1,
  parameter int EDGES_PER_DETENT = 4,
  parameter int SATURATE         = 0
) (
  input logic clk,
  input logic reset,
  quad_encoder_if.slave bus
);
  localparam logic signed [3:0] EDP = 4'(EDGES_PER_DETENT);
  phase_t prev_ab, cur_ab;
  dir_t dir;
  logic primed, up, dn, inc, dec, error;
  logic signed [3:0] acc, acc_nx;
  logic [WIDTH-1:0] val, up_val, dn_val;
  logic [WIDTH:0] sum, dif;
  assign cur_ab = {bus.a, bus.b};
  assign bus.value = val;
  assign bus.inc = inc;
  assign bus.dec = dec;
  assign bus.error = error;
  quad_dir_decode u_dir (.prev_ab(prev_ab), .cur_ab(cur_ab), .dir(dir));
  always_comb begin
    acc_nx = acc + (dir == DIR_FWD ? 4'sd1 : dir == DIR_REV ? -4'sd1 : 4'sd0);
    up = dir == DIR_FWD && acc_nx == EDP;
    dn = dir == DIR_REV && acc_nx == -EDP;
    sum = {1'b0, val} + (WIDTH+1)'(STEP);
    dif = {1'b0, val} - (WIDTH+1)'(STEP);
    up_val = SATURATE != 0 && sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    dn_val = SATURATE != 0 && dif[WIDTH] ? {WIDTH{1'b0}} : dif[WIDTH-1:0];
  end
  // The first edge after release only captures the phases, so a non-00 resting level is not decoded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      primed  <= 1'b0;
      prev_ab <= PH_00;
      acc     <= '0;
      val     <= '0;
      inc     <= 1'b0;
      dec     <= 1'b0;
      error   <= 1'b0;
    end else begin
      primed  <= 1'b1;
      prev_ab <= cur_ab;
      inc     <= primed && up && !bus.load;
      dec     <= primed && dn && !bus.load;
      error   <= primed && dir == DIR_ILLEGAL;
      acc     <= !primed || bus.load || up || dn || dir == DIR_ILLEGAL ? 4'sd0 : acc_nx;
      val     <= bus.load ? bus.load_value : !primed ? val : up ? up_val : dn ? dn_val : val;
    end
  end
endmodule
